// File: rtl/ipc_queue.sv
// IPC command/reply engine with a keycode FIFO behind it: decodes 4-bit host
// commands bit-serially and shifts status or queued keystrokes back to the host.
module ipc_queue #(
  parameter int KEY_DEPTH  = 8,
  parameter int MAX_REPORT = 7
) (
  input  logic       clk_bus,
  input  logic       reset,
  input  logic       ipc_bit_strobe,
  input  logic       ipc_bit,
  output logic       ipc_reply_bit,
  output logic       ipc_busy,
  input  logic       key_valid,
  input  logic [8:0] key_code,
  input  logic       key_pressed,
  output logic       key_full,
  output logic [3:0] unexpected_cmd
);

  localparam int PTR_W   = $clog2(KEY_DEPTH);
  localparam int CNT_W   = $clog2(KEY_DEPTH + 1);
  localparam int REPLY_W = 4 + 12 * MAX_REPORT;
  localparam int LEN_W   = $clog2(REPLY_W + 1);

  localparam logic [3:0] CMD_STATUS = 4'h1;
  localparam logic [3:0] CMD_KEYS   = 4'h8;
  localparam logic [3:0] CMD_FLUSH  = 4'hD;

  // Only three history bits matter: the fourth command bit arrives live on
  // the decoding strobe.
  logic [2:0]         cmdHist_q, cmdHist_d;
  logic [1:0]         bitCnt_q, bitCnt_d;
  logic [REPLY_W-1:0] replySr_q, replySr_d;
  logic [LEN_W-1:0]   replyLen_q, replyLen_d;
  logic               replyBit_q, replyBit_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [3:0]         unexpected_q, unexpected_d;
  logic [8:0]         fifoMem_q [KEY_DEPTH];

  logic [3:0]         nibble;
  logic               decodeEn;
  logic               fifoFull;
  logic               doFlush;
  logic               doPop;
  logic               pushOk;
  logic               pushDrop;
  logic [2:0]         popN;
  logic [2:0]         popAmt;
  logic [7:0]         statusByte;
  logic [REPLY_W-1:0] keyPayload;
  logic [PTR_W-1:0]   rdIdx;

  assign fifoFull       = (count_q == CNT_W'(KEY_DEPTH));
  assign key_full       = fifoFull;
  assign ipc_busy       = (replyLen_q != '0);
  assign ipc_reply_bit  = replyBit_q;
  assign unexpected_cmd = unexpected_q;

  assign nibble   = {cmdHist_q, ipc_bit};
  assign decodeEn = ipc_bit_strobe && (replyLen_q == '0) && (bitCnt_q == 2'd3);
  assign doFlush  = decodeEn && (nibble == CMD_FLUSH);
  assign doPop    = decodeEn && (nibble == CMD_KEYS);
  assign pushOk   = key_valid && !fifoFull && !doFlush;
  assign pushDrop = key_valid && fifoFull && !doFlush;
  assign popN     = (int'(count_q) > MAX_REPORT) ? 3'(MAX_REPORT) : 3'(count_q);
  assign popAmt   = doPop ? popN : 3'd0;

  assign statusByte = {5'b00000, overflow_q, fifoFull, (count_q != '0)};

  // Keyboard reply image, left-aligned so the shifter always emits from the MSB.
  always_comb begin
    keyPayload = '0;
    rdIdx      = rdPtr_q;
    keyPayload[REPLY_W-1 -: 4] = {key_pressed, popN};
    for (int i = 0; i < MAX_REPORT; i++) begin
      rdIdx = rdPtr_q + PTR_W'(i);
      if (i < int'(popN)) begin
        keyPayload[REPLY_W-5-12*i -: 12] =
          {1'b0, fifoMem_q[rdIdx][8:6], 2'b00, fifoMem_q[rdIdx][5:0]};
      end
    end
  end

  always_comb begin
    cmdHist_d    = cmdHist_q;
    bitCnt_d     = bitCnt_q;
    replySr_d    = replySr_q;
    replyLen_d   = replyLen_q;
    replyBit_d   = replyBit_q;
    unexpected_d = unexpected_q;
    overflow_d   = overflow_q;

    if (ipc_bit_strobe) begin
      if (replyLen_q != '0) begin
        replyBit_d = replySr_q[REPLY_W-1];
        replySr_d  = replySr_q << 1;
        replyLen_d = replyLen_q - LEN_W'(1);
      end else begin
        cmdHist_d = nibble[2:0];
        bitCnt_d  = bitCnt_q + 2'd1;
        if (bitCnt_q == 2'd3) begin
          case (nibble)
            CMD_STATUS: begin
              replySr_d  = {statusByte, (REPLY_W-8)'(0)};
              replyLen_d = LEN_W'(8);
              replyBit_d = 1'b0;
              overflow_d = 1'b0;
            end
            CMD_KEYS: begin
              replySr_d  = keyPayload;
              replyLen_d = LEN_W'(4 + 12 * int'(popN));
              replyBit_d = 1'b0;
            end
            CMD_FLUSH: begin
              overflow_d = 1'b0;
            end
            default: begin
              if (unexpected_q == 4'h0) begin
                unexpected_d = nibble;
              end
            end
          endcase
        end
      end
    end

    // A drop in the same cycle as a status read is a fresh event, so it wins.
    if (pushDrop) begin
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    rdPtr_d = rdPtr_q + PTR_W'(popAmt);
    wrPtr_d = wrPtr_q + PTR_W'(pushOk);
    count_d = count_q - CNT_W'(popAmt) + CNT_W'(pushOk);
    if (doFlush) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_bus) begin
    if (reset) begin
      cmdHist_q    <= '0;
      bitCnt_q     <= '0;
      replySr_q    <= '0;
      replyLen_q   <= '0;
      replyBit_q   <= 1'b0;
      rdPtr_q      <= '0;
      wrPtr_q      <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      unexpected_q <= 4'h0;
    end else begin
      cmdHist_q    <= cmdHist_d;
      bitCnt_q     <= bitCnt_d;
      replySr_q    <= replySr_d;
      replyLen_q   <= replyLen_d;
      replyBit_q   <= replyBit_d;
      rdPtr_q      <= rdPtr_d;
      wrPtr_q      <= wrPtr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      unexpected_q <= unexpected_d;
    end
  end

  // Storage needs no reset: entries are only read below the valid count.
  always_ff @(posedge clk_bus) begin
    if (pushOk && !reset) begin
      fifoMem_q[wrPtr_q] <= key_code;
    end
  end

endmodule

// File: tb/tb_ipc_queue.sv
// Directed bench for ipc_queue: a queue-based model checked every cycle, plus
// hand-computed reply words for the documented scenarios.
module tb_ipc_queue;

  localparam int DEPTH = 8;
  localparam int MAXR  = 7;

  logic       clk_bus = 1'b0;
  logic       reset;
  logic       ipc_bit_strobe;
  logic       ipc_bit;
  logic       ipc_reply_bit;
  logic       ipc_busy;
  logic       key_valid;
  logic [8:0] key_code;
  logic       key_pressed;
  logic       key_full;
  logic [3:0] unexpected_cmd;

  int vectors     = 0;
  int miscompares = 0;
  bit checkEn     = 1'b0;

  ipc_queue #(.KEY_DEPTH(DEPTH), .MAX_REPORT(MAXR)) dut (
    .clk_bus        (clk_bus),
    .reset          (reset),
    .ipc_bit_strobe (ipc_bit_strobe),
    .ipc_bit        (ipc_bit),
    .ipc_reply_bit  (ipc_reply_bit),
    .ipc_busy       (ipc_busy),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .key_pressed    (key_pressed),
    .key_full       (key_full),
    .unexpected_cmd (unexpected_cmd)
  );

  always #5 clk_bus = ~clk_bus;

  // Model: pending reply bits as a queue, FIFO contents as a queue of keys.
  bit         mReply [$];
  logic [8:0] keyQ [$];
  logic       mReplyBit = 1'b0;
  int         mCnt = 0;
  logic [3:0] mHist = 4'h0;
  logic       mOv = 1'b0;
  logic [3:0] mUnexp = 4'h0;
  logic [3:0] mNib;
  logic [7:0] mStat;
  logic [8:0] mKey;
  logic [11:0] mWord;
  int         mPre;
  int         mN;
  bit         mFlush;

  always @(posedge clk_bus) begin
    if (reset) begin
      mReply.delete();
      keyQ.delete();
      mReplyBit = 1'b0;
      mCnt = 0;
      mHist = 4'h0;
      mOv = 1'b0;
      mUnexp = 4'h0;
    end else begin
      mPre = keyQ.size();
      mFlush = 1'b0;
      if (ipc_bit_strobe) begin
        if (mReply.size() != 0) begin
          mReplyBit = mReply.pop_front();
        end else begin
          mNib = {mHist[2:0], ipc_bit};
          mHist = mNib;
          if (mCnt == 3) begin
            if (mNib == 4'h1) begin
              mStat = {5'b0, mOv, mPre == DEPTH, mPre != 0};
              for (int b = 7; b >= 0; b--) mReply.push_back(mStat[b]);
              mReplyBit = 1'b0;
              mOv = 1'b0;
            end else if (mNib == 4'h8) begin
              mN = (mPre < MAXR) ? mPre : MAXR;
              mWord = {8'h00, key_pressed, 3'(mN)};
              for (int b = 3; b >= 0; b--) mReply.push_back(mWord[b]);
              for (int j = 0; j < mN; j++) begin
                mKey = keyQ.pop_front();
                mWord = {1'b0, mKey[8:6], 2'b00, mKey[5:0]};
                for (int b = 11; b >= 0; b--) mReply.push_back(mWord[b]);
              end
              mReplyBit = 1'b0;
            end else if (mNib == 4'hD) begin
              keyQ.delete();
              mOv = 1'b0;
              mFlush = 1'b1;
            end else if (mUnexp == 4'h0) begin
              mUnexp = mNib;
            end
          end
          mCnt = (mCnt + 1) % 4;
        end
      end
      if (key_valid && !mFlush) begin
        if (mPre < DEPTH) keyQ.push_back(key_code);
        else mOv = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  always @(negedge clk_bus) begin
    if (checkEn) begin
      checkOutput("busy", 128'(ipc_busy), 128'(mReply.size() != 0));
      checkOutput("reply_bit", 128'(ipc_reply_bit), 128'(mReplyBit));
      checkOutput("key_full", 128'(key_full), 128'(keyQ.size() == DEPTH));
      checkOutput("unexpected_cmd", 128'(unexpected_cmd), 128'(mUnexp));
    end
  end

  task automatic applyStimulus(input logic strobe, input logic b,
                               input logic kv, input logic [8:0] kc);
    @(negedge clk_bus);
    ipc_bit_strobe = strobe;
    ipc_bit        = b;
    key_valid      = kv;
    key_code       = kc;
  endtask

  task automatic sendCmd(input logic [3:0] nib, input logic kvLast, input logic [8:0] kc);
    for (int i = 3; i >= 0; i--) applyStimulus(1'b1, nib[i], (i == 0) && kvLast, kc);
    applyStimulus(1'b0, 1'b0, 1'b0, 9'h0);
  endtask

  task automatic pushKey(input logic [8:0] kc);
    applyStimulus(1'b0, 1'b0, 1'b1, kc);
    applyStimulus(1'b0, 1'b0, 1'b0, 9'h0);
  endtask

  task automatic readReply(input int n, output logic [127:0] bits);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 9'h0);
      @(posedge clk_bus);
      #1;
      bits = {bits[126:0], ipc_reply_bit};
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 9'h0);
  endtask

  logic [127:0] rb;

  initial begin
    reset = 1'b1;
    ipc_bit_strobe = 1'b0;
    ipc_bit = 1'b0;
    key_valid = 1'b0;
    key_code = 9'h0;
    key_pressed = 1'b0;
    @(negedge clk_bus);
    @(negedge clk_bus);
    checkOutput("reset busy", 128'(ipc_busy), 128'd0);
    checkOutput("reset reply_bit", 128'(ipc_reply_bit), 128'd0);
    checkOutput("reset key_full", 128'(key_full), 128'd0);
    checkOutput("reset unexpected", 128'(unexpected_cmd), 128'd0);
    reset = 1'b0;
    checkEn = 1'b1;

    sendCmd(4'h1, 1'b0, 9'h0);
    readReply(8, rb);
    checkOutput("status empty", rb, 128'h00);
    pushKey(9'h041);
    sendCmd(4'h1, 1'b0, 9'h0);
    readReply(8, rb);
    checkOutput("status one key", rb, 128'h01);

    sendCmd(4'hD, 1'b0, 9'h0);
    pushKey(9'h041);
    pushKey(9'h1C5);
    sendCmd(4'h8, 1'b0, 9'h0);
    checkOutput("leading zero", 128'(ipc_reply_bit), 128'd0);
    readReply(28, rb);
    checkOutput("two-key report", rb, 128'h2101705);
    checkOutput("busy after report", 128'(ipc_busy), 128'd0);
    sendCmd(4'h1, 1'b0, 9'h0);
    readReply(8, rb);
    checkOutput("status drained", rb, 128'h00);

    key_pressed = 1'b1;
    sendCmd(4'h8, 1'b0, 9'h0);
    readReply(4, rb);
    checkOutput("empty report held", rb, 128'h8);
    key_pressed = 1'b0;

    for (int i = 1; i <= DEPTH + 1; i++) pushKey({3'(i % 8), 6'(i + 16)});
    checkOutput("key_full after overfill", 128'(key_full), 128'd1);
    sendCmd(4'h1, 1'b0, 9'h0);
    readReply(8, rb);
    checkOutput("status overflow", rb, 128'h07);
    sendCmd(4'h1, 1'b0, 9'h0);
    readReply(8, rb);
    checkOutput("status overflow cleared", rb, 128'h03);

    sendCmd(4'h8, 1'b0, 9'h0);
    readReply(88, rb);
    checkOutput("max report header", rb[87:84], 128'h7);
    checkOutput("max report first key", rb[83:72], 128'h111);
    checkOutput("busy after max report", 128'(ipc_busy), 128'd0);
    sendCmd(4'h8, 1'b0, 9'h0);
    readReply(16, rb);
    checkOutput("remaining key report", rb, 128'h1018);

    sendCmd(4'hD, 1'b0, 9'h0);
    pushKey(9'h1FF);
    pushKey(9'h002);
    sendCmd(4'h8, 1'b1, 9'h100);
    readReply(28, rb);
    checkOutput("pop with push", rb, 128'h273F002);
    sendCmd(4'h8, 1'b0, 9'h0);
    readReply(16, rb);
    checkOutput("pushed key later", rb, 128'h1400);

    pushKey(9'h033);
    sendCmd(4'hD, 1'b1, 9'h055);
    sendCmd(4'h1, 1'b0, 9'h0);
    readReply(8, rb);
    checkOutput("flush beats push", rb, 128'h00);

    sendCmd(4'h5, 1'b0, 9'h0);
    checkOutput("unexpected first", 128'(unexpected_cmd), 128'h5);
    checkOutput("unexpected no busy", 128'(ipc_busy), 128'd0);
    sendCmd(4'h3, 1'b0, 9'h0);
    checkOutput("unexpected sticky", 128'(unexpected_cmd), 128'h5);

    pushKey(9'h0AB);
    sendCmd(4'h8, 1'b0, 9'h0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 9'h0);
    @(posedge clk_bus);
    #1;
    checkOutput("mid-reply bit", 128'(ipc_reply_bit), 128'd1);
    checkOutput("mid-reply busy", 128'(ipc_busy), 128'd1);
    @(negedge clk_bus);
    reset = 1'b1;
    ipc_bit_strobe = 1'b1;
    key_valid = 1'b1;
    key_code = 9'h07E;
    @(posedge clk_bus);
    #1;
    checkOutput("reset abandons busy", 128'(ipc_busy), 128'd0);
    checkOutput("reset clears bit", 128'(ipc_reply_bit), 128'd0);
    checkOutput("reset clears unexpected", 128'(unexpected_cmd), 128'd0);
    @(negedge clk_bus);
    reset = 1'b0;
    ipc_bit_strobe = 1'b0;
    key_valid = 1'b0;
    sendCmd(4'h1, 1'b0, 9'h0);
    readReply(8, rb);
    checkOutput("push ignored in reset", rb, 128'h00);

    applyStimulus(1'b0, 1'b0, 1'b0, 9'h0);
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
